// File: rtl/lcd_pb_controller.sv
// HD44780-style 4-bit LCD write sequencer that time-shares the lcd_data/lcd_rs pads with push-button sampling.
// Latency: ack to IDLE = 2*(E_SETUP+E_HIGH+E_HOLD) + delay + 2 cycles (one nibble fewer for single_nibble).
// Backpressure: lcd_in_ack only pulses in IDLE with no sample pending; a held lcd_in_stb simply waits.
//
// Ports:
//   clk, rst                 clk_50 domain, synchronous active-high reset
//   lcd_in/_stb/_ack         command word {long_delay, single_nibble, rs, byte[7:0]} and its handshake
//   lcd_data_out, lcd_rs_out pad drive values; lcd_oe enables the pad drivers; lcd_e is the LCD strobe
//   lcd_data_in, lcd_rs_in   pad readback used for button sampling (pulled up, pressed = low)
//   pb_out                   debounced pressed flags {rs, data[3:0]} in [4:0]
//   busy                     high whenever the sequencer is not idle
module lcd_pb_controller #(
  parameter int E_SETUP_CLOCKS    = 4,
  parameter int E_HIGH_CLOCKS     = 25,
  parameter int E_HOLD_CLOCKS     = 25,
  parameter int CMD_DELAY_CLOCKS  = 2500,
  parameter int LONG_DELAY_CLOCKS = 100000,
  parameter int SETTLE_CLOCKS     = 8,
  parameter int SAMPLE_PERIOD     = 50000,
  parameter int DEBOUNCE_COUNT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lcd_in,
  input  logic        lcd_in_stb,
  output logic        lcd_in_ack,
  output logic [3:0]  lcd_data_out,
  output logic        lcd_rs_out,
  output logic        lcd_e,
  output logic        lcd_oe,
  input  logic [3:0]  lcd_data_in,
  input  logic        lcd_rs_in,
  output logic [31:0] pb_out,
  output logic        busy
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared down-counter times every state, so it is sized for the longest wait.
  localparam int MAX_WAIT = max_of(max_of(max_of(E_SETUP_CLOCKS, E_HIGH_CLOCKS),
                                          max_of(E_HOLD_CLOCKS, CMD_DELAY_CLOCKS)),
                                   max_of(LONG_DELAY_CLOCKS, SETTLE_CLOCKS));
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  // Holds values up to DEBOUNCE_COUNT so the increment can never wrap.
  localparam int DW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    DELAY,
    RELEASE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [10:0]     cmd;            // {long_delay, single_nibble, rs, byte}
  logic            low_nibble;     // second nibble of the byte is on the bus
  logic            sample_pending;
  logic [TW-1:0]   sample_timer;
  logic            timer_wrap;
  logic [4:0]      pin_meta;
  logic [4:0]      pin_sync;
  logic [4:0]      raw_pressed;
  logic [4:0]      pb_state;
  logic [DW-1:0]   deb_cnt [5];
  logic            unused_lcd_in;

  assign timer_wrap  = (sample_timer == TW'(SAMPLE_PERIOD - 1));
  assign raw_pressed = ~pin_sync;
  assign pb_out      = {27'd0, pb_state};
  assign unused_lcd_in = ^lcd_in[31:11];

  // Accept is combinational so a producer holding stb sees the pulse in the
  // very cycle the word is taken; it can only ever rise in IDLE.
  assign lcd_in_ack = !rst && (state == IDLE) && !sample_pending && lcd_in_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cmd            <= '0;
      low_nibble     <= 1'b0;
      sample_pending <= 1'b0;
      sample_timer   <= '0;
      pin_meta       <= '1;
      pin_sync       <= '1;
      pb_state       <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
      lcd_data_out   <= '0;
      lcd_rs_out     <= 1'b0;
      lcd_e          <= 1'b0;
      lcd_oe         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Buttons are asynchronous to clk_50; SETTLE is long enough to flush this
      // two-stage synchroniser after the pads are released.
      pin_meta <= {lcd_rs_in, lcd_data_in};
      pin_sync <= pin_meta;

      sample_timer <= timer_wrap ? '0 : sample_timer + TW'(1);

      // A wrap during SAMPLE starts a new period, so setting wins over clearing.
      if (timer_wrap)
        sample_pending <= 1'b1;
      else if (state == SAMPLE)
        sample_pending <= 1'b0;

      // Outputs are registered: each transition writes the values the next state drives.
      case (state)
        IDLE: begin
          if (sample_pending) begin
            state    <= SETTLE;
            wait_cnt <= CW'(SETTLE_CLOCKS - 1);
            busy     <= 1'b1;
          end else if (lcd_in_stb) begin
            cmd          <= lcd_in[10:0];
            low_nibble   <= 1'b0;
            lcd_data_out <= lcd_in[7:4];
            lcd_rs_out   <= lcd_in[8];
            lcd_oe       <= 1'b1;
            lcd_e        <= 1'b0;
            busy         <= 1'b1;
            wait_cnt     <= CW'(E_SETUP_CLOCKS - 1);
            state        <= SETUP;
          end
        end

        SETUP: begin
          if (wait_cnt == '0) begin
            state    <= E_HIGH;
            lcd_e    <= 1'b1;
            wait_cnt <= CW'(E_HIGH_CLOCKS - 1);
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        E_HIGH: begin
          if (wait_cnt == '0) begin
            state    <= HOLD;
            lcd_e    <= 1'b0;
            wait_cnt <= CW'(E_HOLD_CLOCKS - 1);
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        HOLD: begin
          if (wait_cnt == '0) begin
            if (!low_nibble && !cmd[9]) begin
              low_nibble   <= 1'b1;
              lcd_data_out <= cmd[3:0];
              wait_cnt     <= CW'(E_SETUP_CLOCKS - 1);
              state        <= SETUP;
            end else begin
              wait_cnt <= cmd[10] ? CW'(LONG_DELAY_CLOCKS - 1) : CW'(CMD_DELAY_CLOCKS - 1);
              state    <= DELAY;
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        // The bus stays driven through the post-byte wait so a pending sample
        // never splits a write.
        DELAY: begin
          if (wait_cnt == '0) begin
            state  <= RELEASE;
            lcd_oe <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        SETTLE: begin
          if (wait_cnt == '0)
            state <= SAMPLE;
          else
            wait_cnt <= wait_cnt - CW'(1);
        end

        SAMPLE: begin
          for (int i = 0; i < 5; i++) begin
            if (raw_pressed[i] != pb_state[i]) begin
              if (deb_cnt[i] == DW'(DEBOUNCE_COUNT - 1)) begin
                pb_state[i] <= ~pb_state[i];
                deb_cnt[i]  <= '0;
              end else begin
                deb_cnt[i] <= deb_cnt[i] + DW'(1);
              end
            end else begin
              deb_cnt[i] <= '0;
            end
          end
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          lcd_e  <= 1'b0;
          lcd_oe <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pb_controller.sv
// Directed bench for lcd_pb_controller with shortened delays and a 150-cycle sample period.
module tb_lcd_pb_controller;

  localparam int SP  = 4;
  localparam int EH  = 25;
  localparam int HD  = 25;
  localparam int CD  = 60;
  localparam int LD  = 400;
  localparam int ST  = 8;
  localparam int PER = 150;
  localparam int DB  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lcd_in;
  logic        lcd_in_stb;
  logic        lcd_in_ack;
  logic [3:0]  lcd_data_out;
  logic        lcd_rs_out;
  logic        lcd_e;
  logic        lcd_oe;
  logic [3:0]  lcd_data_in;
  logic        lcd_rs_in;
  logic [31:0] pb_out;
  logic        busy;

  always #5 clk = ~clk;

  lcd_pb_controller #(
    .E_SETUP_CLOCKS(SP), .E_HIGH_CLOCKS(EH), .E_HOLD_CLOCKS(HD),
    .CMD_DELAY_CLOCKS(CD), .LONG_DELAY_CLOCKS(LD), .SETTLE_CLOCKS(ST),
    .SAMPLE_PERIOD(PER), .DEBOUNCE_COUNT(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .lcd_in(lcd_in), .lcd_in_stb(lcd_in_stb), .lcd_in_ack(lcd_in_ack),
    .lcd_data_out(lcd_data_out), .lcd_rs_out(lcd_rs_out),
    .lcd_e(lcd_e), .lcd_oe(lcd_oe),
    .lcd_data_in(lcd_data_in), .lcd_rs_in(lcd_rs_in),
    .pb_out(pb_out), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-run monitor: protocol invariants and every nibble strobed into the LCD.
  int         ack_seen = 0;
  int         viol_e   = 0;
  int         viol_ack = 0;
  logic       e_prev   = 1'b0;
  logic [4:0] nib_q [$];

  always @(negedge clk) begin
    if (lcd_in_ack) ack_seen <= ack_seen + 1;
    if (lcd_e && !lcd_oe) viol_e <= viol_e + 1;
    if (lcd_in_ack && busy) viol_ack <= viol_ack + 1;
    if (lcd_e && !e_prev) nib_q.push_back({lcd_rs_out, lcd_data_out});
    e_prev <= lcd_e;
  end

  // Per-cycle trace of the first 320 cycles after reset release.
  logic       tr_e    [0:319];
  logic       tr_oe   [0:319];
  logic       tr_busy [0:319];
  logic       tr_ack  [0:319];
  logic       tr_rs   [0:319];
  logic [3:0] tr_data [0:319];

  function automatic int sum_tr(input int sel, input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) begin
      case (sel)
        0: s += int'(tr_e[i]);
        1: s += int'(tr_oe[i]);
        2: s += int'(tr_busy[i]);
        default: s += int'(tr_ack[i]);
      endcase
    end
    return s;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return lcd_e;
      1: return lcd_oe;
      default: return busy;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int sel, input logic val, input int bound, input string tag);
    int k = 0;
    while (sig(sel) !== val && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(sig(sel)), 32'(val));
  endtask

  task automatic send(input logic [31:0] cmd, input string tag);
    int k = 0;
    lcd_in     = cmd;
    lcd_in_stb = 1'b1;
    #1;
    while (!lcd_in_ack && k < 3000) begin
      step();
      #1;
      k++;
    end
    chk({tag, " ack"}, 32'(lcd_in_ack), 1);
    step();
    lcd_in_stb = 1'b0;
  endtask

  task automatic wait_sample(input string tag);
    wait_sig(2, 1'b1, 1000, {tag, " settle"});
    wait_sig(2, 1'b0, 50, {tag, " done"});
  endtask

  logic [4:0] exp_nib [8];
  int         lat;

  initial begin
    exp_nib = '{5'h14, 5'h11, 5'h03, 5'h00, 5'h01, 5'h15, 5'h0C, 5'h08};
    rst         = 1'b1;
    lcd_in      = 32'h141;
    lcd_in_stb  = 1'b1;
    lcd_data_in = 4'hF;
    lcd_rs_in   = 1'b1;
    repeat (3) step();

    chk("rst oe",   32'(lcd_oe), 0);
    chk("rst e",    32'(lcd_e), 0);
    chk("rst ack",  32'(lcd_in_ack), 0);
    chk("rst pb",   pb_out, 0);
    chk("rst busy", 32'(busy), 0);

    // Cycle 0: first word accepted straight out of reset.
    rst = 1'b0;
    #1;
    chk("ack 0x141", 32'(lcd_in_ack), 1);
    for (int i = 1; i < 320; i++) begin
      step();
      if (i == 3) lcd_in_stb = 1'b0;
      if (i == 150) begin
        lcd_in     = 32'h230;
        lcd_in_stb = 1'b1;
      end
      if (i > 150 && tr_ack[i-1]) lcd_in_stb = 1'b0;
      #1;
      tr_e[i]    = lcd_e;
      tr_oe[i]   = lcd_oe;
      tr_busy[i] = busy;
      tr_ack[i]  = lcd_in_ack;
      tr_rs[i]   = lcd_rs_out;
      tr_data[i] = lcd_data_out;
    end

    // 0x141: nibble 4 strobed at 5..29, nibble 1 at 59..83, DELAY 109..168, RELEASE 169.
    chk("setup oe",        32'(tr_oe[1]), 1);
    chk("setup data",      32'(tr_data[1]), 4'h4);
    chk("e low in setup",  32'(tr_e[4]), 0);
    chk("e rise hi nib",   32'(tr_e[5]), 1);
    chk("hi nib data",     32'(tr_data[5]), 4'h4);
    chk("hi nib rs",       32'(tr_rs[5]), 1);
    chk("hi nib e width",  sum_tr(0, 1, 54), EH);
    chk("e last high",     32'(tr_e[29]), 1);
    chk("e fall",          32'(tr_e[30]), 0);
    chk("e low 2nd setup", 32'(tr_e[58]), 0);
    chk("e rise lo nib",   32'(tr_e[59]), 1);
    chk("lo nib data",     32'(tr_data[59]), 4'h1);
    chk("lo nib e width",  sum_tr(0, 55, 108), EH);
    chk("oe held thru wr", sum_tr(1, 1, 168), 168);
    chk("oe fall 169",     32'(tr_oe[169]), 0);
    chk("busy release",    32'(tr_busy[169]), 1);
    chk("idle one cycle",  32'(tr_busy[170]), 0);
    chk("settle starts",   32'(tr_busy[171]), 1);
    chk("settle oe low",   32'(tr_oe[171]), 0);
    chk("settle+sample",   sum_tr(2, 171, 179), ST + 1);
    chk("no e after byte", sum_tr(0, 109, 180), 0);
    chk("no early ack",    sum_tr(3, 1, 179), 0);
    chk("ack after sample", 32'(tr_ack[180]), 1);
    chk("single ack",      sum_tr(3, 1, 319), 1);
    chk("busy 0 at ack",   32'(tr_busy[180]), 0);

    // 0x230: single nibble 3 strobed at 185..209, RELEASE at 295.
    chk("sn e low setup",  32'(tr_e[184]), 0);
    chk("sn e rise",       32'(tr_e[185]), 1);
    chk("sn data",         32'(tr_data[185]), 4'h3);
    chk("sn rs",           32'(tr_rs[185]), 0);
    chk("sn one pulse",    sum_tr(0, 181, 319), EH);
    chk("sn oe in delay",  32'(tr_oe[294]), 1);
    chk("sn oe fall",      32'(tr_oe[295]), 0);
    chk("sn idle",         32'(tr_busy[296]), 0);

    // 0x401: long delay, oe falls 2*54 + LD + 1 cycles after the ack.
    send(32'h401, "long");
    lat = 1;
    while (lcd_oe === 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
    chk("long oe latency", lat, 2 * (SP + EH + HD) + LD + 1);
    step();

    // Debounce: rs and data[0] pressed -> 0x11 on the 4th sample only.
    wait_sample("align1");
    lcd_data_in = 4'hE;
    lcd_rs_in   = 1'b0;
    repeat (3) wait_sample("press");
    chk("pb after 3", pb_out, 32'h00);
    wait_sample("press4");
    chk("pb after 4", pb_out, 32'h11);
    lcd_data_in = 4'hF;
    lcd_rs_in   = 1'b1;
    repeat (3) wait_sample("release");
    chk("pb hold 3 rel", pb_out, 32'h11);

    // Reset in E_HIGH of the first nibble.
    send(32'h155, "rst cmd");
    wait_sig(0, 1'b1, 200, "rst cmd e");
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid rst e",    32'(lcd_e), 0);
    chk("mid rst oe",   32'(lcd_oe), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst pb",   pb_out, 0);
    rst = 1'b0;

    send(32'h0C8, "post rst");
    wait_sig(0, 1'b1, 100, "post rst e1");
    chk("post rst d1", 32'(lcd_data_out), 4'hC);
    chk("post rst rs", 32'(lcd_rs_out), 0);
    wait_sig(0, 1'b0, 100, "post rst e1 fall");
    wait_sig(0, 1'b1, 100, "post rst e2");
    chk("post rst d2", 32'(lcd_data_out), 4'h8);
    wait_sig(1, 1'b0, 500, "post rst oe");
    step();

    // Glitch: 3 pressed samples then release leaves pb at 0, and the counter restarts.
    wait_sample("align2");
    lcd_data_in = 4'hE;
    repeat (3) wait_sample("glitch");
    chk("glitch 3", pb_out, 32'h00);
    lcd_data_in = 4'hF;
    repeat (2) wait_sample("glitch rel");
    chk("glitch rel", pb_out, 32'h00);
    lcd_data_in = 4'hE;
    wait_sample("repress");
    chk("counter cleared", pb_out, 32'h00);
    lcd_data_in = 4'hF;

    chk("e without oe",   viol_e, 0);
    chk("ack while busy", viol_ack, 0);
    chk("ack total",      ack_seen, 5);
    chk("nibble count",   nib_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("nibble %0d", i), (i < nib_q.size()) ? 32'(nib_q[i]) : 32'h1F, 32'(exp_nib[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
